spi_master_ctrl: RTL and testbench

- Single-clock SPI master that generates the 10-bit command frames consumed by the team's SPI slave + single-port RAM subsystem (ss_n, mosi, miso, all synchronous to clk).
- Frame = 2-bit command + 8-bit payload, sent MSB first.
- For read-data commands (cmd = 2'b11) the block also captures the 8-bit byte returned on miso.
- Sits between a host/test sequencer and the spi top level; drives the SPI pins directly, no clock division.

---
 rtl/spi_master_ctrl.sv | 152 +++++++++++++++
 tb/tb_spi_master_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   Single-clock SPI master that issues 10-bit command frames ({cmd, payload},
//   MSB first) to the SPI slave + RAM subsystem. For read-data frames
//   (cmd = 2'b11) it also shifts in the 8-bit byte returned on miso.
//   No clock division: every SPI bit lasts one clk cycle.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        frame request, only looked at in IDLE
//   cmd[1:0]     00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   wdata[7:0]   payload, latched together with cmd on accept
//   busy         high from the accept edge until the FSM is back in IDLE
//   done         one-cycle pulse at frame end
//   rdata[7:0]   byte from the most recent completed rd-data frame
//   rdata_valid  one-cycle pulse with done, rd-data frames only
//   ss_n         slave select, active low
//   mosi         serial data to the slave
//   miso         serial data from the slave
//
// Handshake: start is a level request. It is accepted on a rising edge where
// the FSM is in IDLE; requests while busy are dropped, not queued. Holding
// start high gives back-to-back frames separated by two ss_n-high cycles.
module spi_master_ctrl #(
  parameter int RD_WAIT = 2  // cycles between last mosi bit and first miso sample, 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LEAD     = 3'd1,
    S_SHIFT_TX = 3'd2,
    S_WAIT_RX  = 3'd3,
    S_SHIFT_RX = 3'd4,
    S_END      = 3'd5
  } state_t;

  // The WAIT_RX state covers RD_WAIT-1 cycles: the transition edge out of
  // WAIT_RX (or straight out of SHIFT_TX when RD_WAIT is 1) already places
  // the FSM in SHIFT_RX so the first miso sample lands RD_WAIT cycles after
  // the last mosi bit ended.
  localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 2);
  localparam logic       NO_WAIT   = (RD_WAIT == 1);

  state_t     state_q;
  state_t     state_d;
  logic [9:0] tx_sh;    // frame being shifted out, tx_sh[9] is on mosi
  logic [6:0] rx_sh;    // the first seven miso samples of a read
  logic [3:0] cnt;      // bit / wait counter, counts down to zero
  logic       is_rd;    // frame in flight is a rd-data command
  logic [7:0] rdata_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_LEAD;
      S_LEAD:     state_d = S_SHIFT_TX;
      S_SHIFT_TX: begin
        if (cnt == 4'd0) begin
          if (!is_rd)       state_d = S_END;
          else if (NO_WAIT) state_d = S_SHIFT_RX;
          else              state_d = S_WAIT_RX;
        end
      end
      S_WAIT_RX:  if (cnt == 4'd0) state_d = S_SHIFT_RX;
      S_SHIFT_RX: if (cnt == 4'd0) state_d = S_END;
      S_END:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath: frame latch, shift registers, counter, captured byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh   <= '0;
      rx_sh   <= '0;
      cnt     <= '0;
      is_rd   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tx_sh <= {cmd, wdata};
            is_rd <= (cmd == 2'b11);
            cnt   <= 4'd0;
          end
        end
        S_LEAD: begin
          cnt <= 4'd9;
        end
        S_SHIFT_TX: begin
          if (cnt == 4'd0) begin
            cnt <= NO_WAIT ? 4'd7 : WAIT_LOAD;
          end else begin
            cnt   <= cnt - 4'd1;
            tx_sh <= {tx_sh[8:0], 1'b0};
          end
        end
        S_WAIT_RX: begin
          if (cnt == 4'd0) cnt <= 4'd7;
          else             cnt <= cnt - 4'd1;
        end
        S_SHIFT_RX: begin
          rx_sh <= {rx_sh[5:0], miso};
          if (cnt == 4'd0) rdata_q <= {rx_sh, miso};
          else             cnt     <= cnt - 4'd1;
        end
        S_END: begin
          cnt <= 4'd0;
        end
        default: begin
          cnt <= 4'd0;
        end
      endcase
    end
  end

  // Outputs decoded from state. Because the state register resets
  // asynchronously, ss_n rises immediately when a frame is aborted by reset.
  always_comb begin
    busy        = (state_q != S_IDLE);
    ss_n        = (state_q == S_IDLE) || (state_q == S_END);
    mosi        = (state_q == S_SHIFT_TX) && tx_sh[9];
    done        = (state_q == S_END);
    rdata_valid = (state_q == S_END) && is_rd;
    rdata       = rdata_q;
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl.
// A behavioural SPI slave + RAM model decodes what appears on mosi and
// answers rd-data frames on miso; a separate transaction-level RAM model
// predicts the bytes the master must capture.
module tb_spi_master_ctrl;

  localparam int RD_WAIT = 2;
  localparam int WR_LEN  = 11;           // edges from accept to frame end, writes
  localparam int RD_LEN  = 18 + RD_WAIT; // same for rd-data

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] wdata = 8'h00;
  logic       miso = 1'b0;
  logic       busy, done, rdata_valid, ss_n, mosi;
  logic [7:0] rdata;

  spi_master_ctrl #(.RD_WAIT(RD_WAIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cmd         (cmd),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .miso        (miso)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [9:0] exp_q[$];        // frames expected on mosi, in order

  // transaction-level reference of the RAM subsystem
  logic [7:0] ref_mem[256];
  logic [7:0] ref_waddr = 8'h00;
  logic [7:0] ref_raddr = 8'h00;
  logic [7:0] last_rdata = 8'h00;

  // behavioural slave, driven only by the SPI pins
  logic [7:0] s_mem[256];
  logic [7:0] s_waddr = 8'h00;
  logic [7:0] s_raddr = 8'h00;
  logic [7:0] s_tx = 8'h00;
  logic [9:0] s_frame = 10'h000;
  int         sc = 0;          // cycles since ss_n fell, counted at negedge

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- slave model ----------------
  always @(negedge clk) begin
    if (!ss_n) sc++;
    else       sc = 0;
    if (sc >= 2 && sc <= 11) s_frame = {s_frame[8:0], mosi};
    if (sc == 1 || sc > 11) check("mosi_low_outside_bits", mosi, 1'b0);
    if (sc == 11) begin
      if (exp_q.size() == 0) check("unexpected_frame", exp_q.size(), 1);
      else                   check("mosi_frame", s_frame, exp_q.pop_front());
      case (s_frame[9:8])
        2'b00: s_waddr = s_frame[7:0];
        2'b01: s_mem[s_waddr] = s_frame[7:0];
        2'b10: s_raddr = s_frame[7:0];
        default: s_tx = s_mem[s_raddr];
      endcase
    end
    // miso carries noise except where the master is meant to sample it
    if (sc >= 11 + RD_WAIT && sc <= 18 + RD_WAIT) miso = s_tx[7 - (sc - 11 - RD_WAIT)];
    else                                          miso = 1'($urandom);
  end

  // ---------------- driver / checker tasks ----------------
  task automatic note_frame(input logic [1:0] c, input logic [7:0] d);
    exp_q.push_back({c, d});
    case (c)
      2'b00: ref_waddr = d;
      2'b01: ref_mem[ref_waddr] = d;
      2'b10: ref_raddr = d;
      default: ;
    endcase
  endtask

  function automatic logic [7:0] predict_rdata(input logic [1:0] c);
    return (c == 2'b11) ? ref_mem[ref_raddr] : last_rdata;
  endfunction

  // Call with start already high before the accept edge.
  task automatic measure_frame(input logic [1:0] c, input logic [7:0] exp_rd,
                               input logic exp_rv, input int glitch_k, input string tag);
    int k, ss_end, done_k, n_done, n_rv, exp_len;
    exp_len = (c == 2'b11) ? RD_LEN : WR_LEN;
    @(posedge clk); #1;
    start = 1'b0;
    cmd   = 2'($urandom);   // must not affect the frame in flight
    wdata = 8'($urandom);
    check({tag, "_busy_at_accept"}, busy, 1'b1);
    check({tag, "_ss_n_at_accept"}, ss_n, 1'b0);
    k = 0; ss_end = -1; done_k = -1; n_done = 0; n_rv = 0;
    while (busy && k < 80) begin
      @(posedge clk); #1;
      k++;
      start = (k == glitch_k);
      if (k == glitch_k) begin
        cmd   = 2'b01;
        wdata = 8'hFF;
      end
      if (ss_n && ss_end < 0) ss_end = k;
      if (done) begin
        n_done++;
        done_k = k;
      end
      if (rdata_valid) n_rv++;
    end
    start = 1'b0;
    check({tag, "_frame_finished"}, busy, 1'b0);
    check({tag, "_ss_n_rise_edge"}, ss_end, exp_len);
    check({tag, "_done_edge"}, done_k, exp_len);
    check({tag, "_idle_edge"}, k, exp_len + 1);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_rdata_valid_count"}, n_rv, exp_rv ? 1 : 0);
    check({tag, "_rdata"}, rdata, exp_rd);
    last_rdata = exp_rd;
  endtask

  task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input int glitch_k,
                           input logic [7:0] exp_rd, input logic exp_rv, input string tag);
    note_frame(c, d);
    @(negedge clk);
    start = 1'b1;
    cmd   = c;
    wdata = d;
    measure_frame(c, exp_rd, exp_rv, glitch_k, tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] cmd;
    logic [7:0] wdata;
    int         glitch_k;   // edge at which a stray start pulse is injected, 0 = none
    logic [7:0] exp_rdata;
    logic       exp_rv;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int         n_abort;
    int         nd;
    logic [39:0] act_tr, exp_tr;
    logic [1:0] rc;
    logic [7:0] rd;
    logic [7:0] er;

    vecs[0]  = '{2'b00, 8'h10, 0, 8'h00, 1'b0};
    vecs[1]  = '{2'b01, 8'h5A, 0, 8'h00, 1'b0};
    vecs[2]  = '{2'b10, 8'h10, 0, 8'h00, 1'b0};
    vecs[3]  = '{2'b11, 8'h00, 0, 8'h5A, 1'b1};
    vecs[4]  = '{2'b00, 8'h20, 0, 8'h5A, 1'b0};
    vecs[5]  = '{2'b01, 8'h3C, 0, 8'h5A, 1'b0};
    vecs[6]  = '{2'b10, 8'h20, 0, 8'h5A, 1'b0};
    vecs[7]  = '{2'b11, 8'h77, 0, 8'h3C, 1'b1};
    vecs[8]  = '{2'b00, 8'h20, 0, 8'h3C, 1'b0};
    vecs[9]  = '{2'b01, 8'h33, 5, 8'h3C, 1'b0};
    vecs[10] = '{2'b11, 8'h00, 0, 8'h33, 1'b1};
    vecs[11] = '{2'b10, 8'h05, 0, 8'h33, 1'b0};

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i) ^ 8'h5C;
      s_mem[i]   = 8'(i) ^ 8'h5C;
    end

    // Reset with start held: nothing moves until release, then the frame
    // starts on the first edge after release.
    rst_n = 1'b0;
    start = 1'b1;
    cmd   = 2'b00;
    wdata = 8'hA5;
    note_frame(2'b00, 8'hA5);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", ss_n, 1'b1);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rdata_valid", rdata_valid, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    measure_frame(2'b00, 8'h00, 1'b0, 0, "reset_a5");

    // Table: write/read sequences through the RAM, stray start while busy.
    for (int i = 0; i < 12; i++) begin
      run_frame(vecs[i].cmd, vecs[i].wdata, vecs[i].glitch_k,
                vecs[i].exp_rdata, vecs[i].exp_rv, $sformatf("vec%0d", i));
    end

    // Abort a rd-data frame around bit 5 with reset.
    @(negedge clk);
    start = 1'b1;
    cmd   = 2'b11;
    wdata = 8'h42;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ss_n_async", ss_n, 1'b1);
    check("abort_mosi", mosi, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_rdata", rdata, 8'h00);
    n_abort = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || rdata_valid) n_abort++;
    end
    check("abort_no_done", n_abort, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 8'h00;
    run_frame(2'b11, 8'h00, 0, predict_rdata(2'b11), 1'b1, "after_abort");

    // start held high: three frames with two-cycle ss_n gaps.
    for (int i = 0; i < 3; i++) note_frame(2'b00, 8'h77);
    @(negedge clk);
    start = 1'b1;
    cmd   = 2'b00;
    wdata = 8'h77;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      act_tr[k] = ss_n;
      exp_tr[k] = !(((k % 13) <= 10) && (k <= 36));
      if (done) nd++;
      if (k == 26) start = 1'b0;
    end
    check("b2b_ss_n_trace", act_tr, exp_tr);
    check("b2b_done_count", nd, 3);
    check("b2b_idle_after", busy, 1'b0);

    // Random frames against the transaction-level RAM reference.
    for (int i = 0; i < 24; i++) begin
      rc = 2'($urandom_range(0, 3));
      rd = 8'($urandom_range(0, 255));
      er = predict_rdata(rc);
      run_frame(rc, rd, 0, er, rc == 2'b11, $sformatf("rand%0d", i));
    end

    repeat (3) @(posedge clk);
    check("frames_left_in_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
